// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
//   rx_state_t : receiver FSM state encoding
//   baud_div   : clk cycles per oversampling tick, integer-truncated
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    function automatic int unsigned baud_div(
        input int unsigned clock_freq,
        input int unsigned baud_rate,
        input int unsigned ticks_per_bit
    );
        return clock_freq / (baud_rate * ticks_per_bit);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Both flops reset to 1 so the line reads as idle out of reset.
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous reset, active-high
//   d    in   asynchronous input
//   q    out  synchronised output
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: oversampled start detection, LSB-first deserialisation and a
// valid/ready output register carrying frame, parity and overrun error flags.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous reset, active-high
//   rx_in        in   serial line, asynchronous, idles high
//   dout         out  received word, valid while rx_valid = 1
//   rx_valid     out  word available
//   rx_ready     in   consumer accepts word when rx_valid && rx_ready
//   frame_err    out  stop bit sampled 0 (qualified by rx_valid)
//   parity_err   out  parity mismatch (qualified by rx_valid), 0 without parity
//   overrun_err  out  sticky: a word was overwritten before being accepted
//   busy         out  receiver FSM not idle
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned TICKS_PER_BIT = 16,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned BAUD_RATE     = 115_200,
    parameter int unsigned CLOCK_FREQ    = 100_000_000,
    parameter int unsigned PARITY_ODD    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  overrun_err,
    output logic                  busy
);

    localparam int unsigned DIV   = baud_div(CLOCK_FREQ, BAUD_RATE, TICKS_PER_BIT);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned S_W   = $clog2(TICKS_PER_BIT);
    localparam int unsigned N_W   = $clog2(DATA_WIDTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [S_W-1:0]   S_HALF   = S_W'(TICKS_PER_BIT / 2 - 1);
    localparam logic [S_W-1:0]   S_FULL   = S_W'(TICKS_PER_BIT - 1);
    localparam logic [N_W-1:0]   N_LAST   = N_W'(DATA_WIDTH - 1);

    if (TICKS_PER_BIT < 4 || (TICKS_PER_BIT % 2) != 0 || DIV < 1 ||
        DATA_WIDTH < 2 || PARITY_ODD > 1) begin : g_cfg_bad
        $error("uart_rx_core: unsupported parameter combination");
    end

    // ------------------------------------------------------------------
    // Line synchroniser and edge history
    // ------------------------------------------------------------------
    logic rx_s;
    logic rx_prev;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_prev <= 1'b1;
        else     rx_prev <= rx_s;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    rx_state_t             state, state_n;
    logic [S_W-1:0]        s_cnt, s_cnt_n;
    logic [N_W-1:0]        n_cnt, n_cnt_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic                  break_hold, break_hold_n;
    logic                  par_bit, par_bit_n;
    logic                  done;

    // ------------------------------------------------------------------
    // Oversampling tick generator; held at zero while idle so every frame
    // starts its tick phase from the detected falling edge.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (state != IDLE) && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        div_cnt <= '0;
        else if (state == IDLE || tick) div_cnt <= '0;
        else                            div_cnt <= div_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            s_cnt      <= '0;
            n_cnt      <= '0;
            shreg      <= '0;
            break_hold <= 1'b0;
            par_bit    <= 1'b0;
        end else begin
            state      <= state_n;
            s_cnt      <= s_cnt_n;
            n_cnt      <= n_cnt_n;
            shreg      <= shreg_n;
            break_hold <= break_hold_n;
            par_bit    <= par_bit_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n      = state;
        s_cnt_n      = s_cnt;
        n_cnt_n      = n_cnt;
        shreg_n      = shreg;
        break_hold_n = break_hold;
        par_bit_n    = par_bit;
        done         = 1'b0;

        unique case (state)
            IDLE: begin
                // A low stop bit leaves the guard set until the line is seen high.
                if (rx_s) break_hold_n = 1'b0;
                if (!break_hold && rx_prev && !rx_s) begin
                    state_n = START;
                    s_cnt_n = '0;
                end
            end

            START: begin
                if (tick) begin
                    if (s_cnt == S_HALF) begin
                        s_cnt_n = '0;
                        n_cnt_n = '0;
                        state_n = rx_s ? IDLE : DATA;
                    end else begin
                        s_cnt_n = s_cnt + 1'b1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (s_cnt == S_FULL) begin
                        s_cnt_n = '0;
                        shreg_n = {rx_s, shreg[DATA_WIDTH-1:1]};
                        if (n_cnt == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            n_cnt_n = n_cnt + 1'b1;
                        end
                    end else begin
                        s_cnt_n = s_cnt + 1'b1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (s_cnt == S_FULL) begin
                        s_cnt_n   = '0;
                        par_bit_n = rx_s;
                        state_n   = STOP;
                    end else begin
                        s_cnt_n = s_cnt + 1'b1;
                    end
                end
            end
`endif

            STOP: begin
                if (tick) begin
                    if (s_cnt == S_FULL) begin
                        s_cnt_n      = '0;
                        state_n      = IDLE;
                        done         = 1'b1;
                        break_hold_n = ~rx_s;
                    end else begin
                        s_cnt_n = s_cnt + 1'b1;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // ------------------------------------------------------------------
    // Output register with valid/ready handshake and overrun tracking
    // ------------------------------------------------------------------
    logic pe_new;

`ifdef UART_RX_PARITY_EN
    assign pe_new = (^shreg ^ par_bit) != (PARITY_ODD != 0);
`else
    assign pe_new = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout        <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else if (done) begin
            // Completion coinciding with accept hands off the old word and
            // loads the new one without flagging an overrun.
            dout        <= shreg;
            frame_err   <= ~rx_s;
            parity_err  <= pe_new;
            rx_valid    <= 1'b1;
            overrun_err <= rx_valid && !rx_ready;
        end else if (rx_valid && rx_ready) begin
            rx_valid    <= 1'b0;
            overrun_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

    localparam int unsigned CF       = 1_600_000;
    localparam int unsigned BR       = 10_000;
    localparam int unsigned TPB      = 16;
    localparam int unsigned BIT_CLKS = CF / BR;
    localparam int unsigned PAR_ODD  = 0;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned PB = 1;
`else
    localparam int unsigned PB = 0;
`endif
    // Falling edge of start bit to middle of stop bit.
    localparam int unsigned MID_STOP = (1 + 8 + PB) * BIT_CLKS + BIT_CLKS / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic       rx_ready;
    logic [7:0] dout;
    logic       rx_valid, frame_err, parity_err, overrun_err, busy;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned cyc         = 0;

    typedef struct {
        logic [7:0]  d;
        logic        fe;
        logic        pe;
        logic        ov;
        int unsigned cyc;
    } obs_t;

    obs_t obs_q[$];

    uart_rx_core #(
        .TICKS_PER_BIT (TPB),
        .DATA_WIDTH    (8),
        .BAUD_RATE     (BR),
        .CLOCK_FREQ    (CF),
        .PARITY_ODD    (PAR_ODD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .dout        (dout),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted word, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst === 1'b0 && rx_valid === 1'b1 && rx_ready === 1'b1)
            obs_q.push_back('{dout, frame_err, parity_err, overrun_err, cyc});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1);
    end

    // ---------------------------------------------------------------
    // Reference model: frame-level rules
    // ---------------------------------------------------------------
    function automatic logic model_par_bit(input logic [7:0] d, input logic flip);
        int unsigned ones = $countones(d);
        return logic'(((ones + PAR_ODD) % 2) == 1) ^ flip;
    endfunction

    function automatic logic model_pe(input logic [7:0] d, input logic flip);
        int unsigned total;
        if (PB == 0) return 1'b0;
        total = $countones(d) + int'(model_par_bit(d, flip));
        return logic'((total % 2) != PAR_ODD);
    endfunction

    function automatic obs_t pop_obs();
        obs_t o;
        o.d   = 'x;
        o.fe  = 1'bx;
        o.pe  = 1'bx;
        o.ov  = 1'bx;
        o.cyc = 0;
        if (obs_q.size() > 0) o = obs_q.pop_front();
        return o;
    endfunction

    // ---------------------------------------------------------------
    // Drivers (inputs change 1 ns after the rising edge)
    // ---------------------------------------------------------------
    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        rx_in = 1'b1;
        step(n);
    endtask

    // Leaves the line at the stop bit value.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip,
                              output int unsigned t0);
        rx_in = 1'b0;
        t0    = cyc;
        step(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            step(BIT_CLKS);
        end
        if (PB != 0) begin
            rx_in = model_par_bit(d, flip);
            step(BIT_CLKS);
        end
        rx_in = stop;
        step(BIT_CLKS);
    endtask

    task automatic wait_word(input int unsigned budget);
        for (int i = 0; i < int'(budget) && obs_q.size() == 0; i++) step(1);
    endtask

    // ---------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------
    task automatic test_reset();
        rst      = 1'b1;
        rx_in    = 1'b1;
        rx_ready = 1'b0;
        step(5);
        vectors++; if (rx_valid !== 1'b0)    begin miscompares++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        vectors++; if (dout !== 8'h00)       begin miscompares++; $display("FAIL reset_dout: got %h want 00", dout); end
        vectors++; if (frame_err !== 1'b0)   begin miscompares++; $display("FAIL reset_fe: got %b want 0", frame_err); end
        vectors++; if (parity_err !== 1'b0)  begin miscompares++; $display("FAIL reset_pe: got %b want 0", parity_err); end
        vectors++; if (overrun_err !== 1'b0) begin miscompares++; $display("FAIL reset_ov: got %b want 0", overrun_err); end
        vectors++; if (busy !== 1'b0)        begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        step(20);
        vectors++; if (rx_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL post_reset_idle: valid=%b busy=%b want 0 0", rx_valid, busy);
        end
    endtask

    task automatic test_basic();
        int unsigned t0, lat;
        obs_t o;
        rx_ready = 1'b1;
        idle(20);
        send_frame(8'hA5, 1'b1, 1'b0, t0);
        idle(40);
        vectors++; if (obs_q.size() != 1) begin miscompares++; $display("FAIL basic_count: got %0d words want 1", obs_q.size()); end
        o = pop_obs();
        lat = o.cyc - t0;
        vectors++; if (o.d !== 8'hA5)   begin miscompares++; $display("FAIL basic_dout: got %h want a5", o.d); end
        vectors++; if (o.fe !== 1'b0)   begin miscompares++; $display("FAIL basic_fe: got %b want 0", o.fe); end
        vectors++; if (o.ov !== 1'b0)   begin miscompares++; $display("FAIL basic_ov: got %b want 0", o.ov); end
        vectors++; if (lat < MID_STOP || lat > MID_STOP + 8) begin
            miscompares++; $display("FAIL basic_latency: got %0d clk want %0d..%0d", lat, MID_STOP, MID_STOP + 8);
        end
        vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL basic_single_pulse: valid=%b want 0", rx_valid); end
    endtask

    task automatic test_glitch();
        rx_ready = 1'b1;
        idle(20);
        rx_in = 1'b0;
        step(10);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL glitch_busy: got %b want 1", busy); end
        step(30);
        rx_in = 1'b1;
        step(200);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_idle: busy=%b want 0", busy); end
        vectors++; if (obs_q.size() != 0 || rx_valid !== 1'b0) begin
            miscompares++; $display("FAIL glitch_no_word: words=%0d valid=%b want 0 0", obs_q.size(), rx_valid);
        end
    endtask

    task automatic test_break();
        int unsigned t0;
        obs_t o;
        rx_ready = 1'b1;
        idle(20);
        send_frame(8'h3C, 1'b0, 1'b0, t0);
        step(400);
        vectors++; if (obs_q.size() != 1) begin miscompares++; $display("FAIL break_count: got %0d words want 1", obs_q.size()); end
        o = pop_obs();
        vectors++; if (o.d !== 8'h3C) begin miscompares++; $display("FAIL break_dout: got %h want 3c", o.d); end
        vectors++; if (o.fe !== 1'b1) begin miscompares++; $display("FAIL break_fe: got %b want 1", o.fe); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL break_hold_low: busy=%b want 0", busy); end
        idle(20);
        send_frame(8'h5A, 1'b1, 1'b0, t0);
        idle(40);
        vectors++; if (obs_q.size() != 1) begin miscompares++; $display("FAIL break_next_count: got %0d words want 1", obs_q.size()); end
        o = pop_obs();
        vectors++; if (o.d !== 8'h5A || o.fe !== 1'b0) begin
            miscompares++; $display("FAIL break_next_word: got %h fe=%b want 5a fe=0", o.d, o.fe);
        end
    endtask

    task automatic test_overrun();
        int unsigned t0;
        obs_t o;
        rx_ready = 1'b0;
        idle(20);
        send_frame(8'h00, 1'b1, 1'b0, t0);
        vectors++; if (rx_valid !== 1'b1 || dout !== 8'h00 || overrun_err !== 1'b0) begin
            miscompares++; $display("FAIL ovr_first: valid=%b dout=%h ov=%b want 1 00 0", rx_valid, dout, overrun_err);
        end
        send_frame(8'hFF, 1'b1, 1'b0, t0);
        idle(20);
        vectors++; if (rx_valid !== 1'b1)    begin miscompares++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
        vectors++; if (dout !== 8'hFF)       begin miscompares++; $display("FAIL ovr_dout: got %h want ff", dout); end
        vectors++; if (overrun_err !== 1'b1) begin miscompares++; $display("FAIL ovr_flag: got %b want 1", overrun_err); end
        vectors++; if (frame_err !== 1'b0)   begin miscompares++; $display("FAIL ovr_fe: got %b want 0", frame_err); end
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        vectors++; if (rx_valid !== 1'b0 || overrun_err !== 1'b0) begin
            miscompares++; $display("FAIL ovr_accept: valid=%b ov=%b want 0 0", rx_valid, overrun_err);
        end
        vectors++; if (obs_q.size() != 1) begin miscompares++; $display("FAIL ovr_accept_count: got %0d words want 1", obs_q.size()); end
        o = pop_obs();
        vectors++; if (o.d !== 8'hFF || o.ov !== 1'b1) begin
            miscompares++; $display("FAIL ovr_accepted_word: got %h ov=%b want ff ov=1", o.d, o.ov);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned t0;
        logic [7:0] d;
        obs_t o;
        d = 8'($urandom_range(1, 255));
        rx_ready = 1'b0;
        idle(20);
        send_frame(d, 1'b1, 1'b0, t0);
        idle(10);
        vectors++; if (rx_valid !== 1'b1 || dout !== d) begin
            miscompares++; $display("FAIL rstmid_pending: valid=%b dout=%h want 1 %h", rx_valid, dout, d);
        end
        rx_in = 1'b0;
        step(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx_in = d[i];
            step(BIT_CLKS);
        end
        rx_in = d[4];
        step(BIT_CLKS / 2);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy: got %b want 1", busy); end
        rst = 1'b1;
        #1;
        vectors++; if (rx_valid !== 1'b0 || dout !== 8'h00 || frame_err !== 1'b0 ||
                       parity_err !== 1'b0 || overrun_err !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_async: valid=%b dout=%h fe=%b pe=%b ov=%b busy=%b want all 0",
                     rx_valid, dout, frame_err, parity_err, overrun_err, busy);
        end
        step(3);
        rx_in = 1'b1;
        step(2);
        rst      = 1'b0;
        rx_ready = 1'b1;
        idle(20);
        send_frame(8'h81, 1'b1, 1'b0, t0);
        idle(40);
        vectors++; if (obs_q.size() != 1) begin miscompares++; $display("FAIL rstmid_count: got %0d words want 1", obs_q.size()); end
        o = pop_obs();
        vectors++; if (o.d !== 8'h81 || o.fe !== 1'b0 || o.ov !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_next: got %h fe=%b ov=%b want 81 0 0", o.d, o.fe, o.ov);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int unsigned t0;
        obs_t o;
        rx_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            logic flip = (k == 0);
            idle(20);
            send_frame(8'h07, 1'b1, flip, t0);
            idle(40);
            o = pop_obs();
            vectors++; if (o.d !== 8'h07 || o.pe !== model_pe(8'h07, flip)) begin
                miscompares++;
                $display("FAIL parity_%0d: got %h pe=%b want 07 pe=%b", k, o.d, o.pe, model_pe(8'h07, flip));
            end
        end
    endtask
`endif

    task automatic test_random();
        int unsigned t0, lat;
        logic [7:0] d;
        logic stop, flip;
        obs_t o;
        rx_ready = 1'b1;
        idle(20);
        for (int n = 0; n < 10; n++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            flip = (PB != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            send_frame(d, stop, flip, t0);
            idle(4 + $urandom_range(0, 100));
            wait_word(200);
            vectors++; if (obs_q.size() != 1) begin miscompares++; $display("FAIL rnd%0d_count: got %0d words want 1", n, obs_q.size()); end
            o = pop_obs();
            lat = o.cyc - t0;
            vectors++; if (o.d !== d)  begin miscompares++; $display("FAIL rnd%0d_dout: got %h want %h", n, o.d, d); end
            vectors++; if (o.fe !== ~stop) begin miscompares++; $display("FAIL rnd%0d_fe: got %b want %b", n, o.fe, ~stop); end
            vectors++; if (o.pe !== model_pe(d, flip)) begin
                miscompares++; $display("FAIL rnd%0d_pe: got %b want %b", n, o.pe, model_pe(d, flip));
            end
            vectors++; if (o.ov !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_ov: got %b want 0", n, o.ov); end
            vectors++; if (lat < MID_STOP || lat > MID_STOP + 8) begin
                miscompares++; $display("FAIL rnd%0d_latency: got %0d clk want %0d..%0d", n, lat, MID_STOP, MID_STOP + 8);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_overrun();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
